// File: rtl/mrdy_pkg.sv
// ---------------------------------------------------------------------------
// mrdy_pkg -- shared definitions for the MRDY wait-state generator.
//
// Contents:
//   region_e        : decoded address region (ZERO / ROM / EXT)
//   state_e         : wait-state FSM encoding
//   region bounds   : EXT = FC00-FDFF, ROM = C000-FBFF and FFF0-FFFF
//   register addrs  : WSCFG at FF92, STATUS at FF93
//   WSCFG_RST       : WSCFG reset value (EXT = 2 waits, ROM = 0 waits)
//   TIMEOUT_LIMIT   : EXTWAIT edges before the cycle is forcibly released
//   in_range()      : inclusive address range helper
//
// Optional feature macro used by the consumers of this package:
//   MRDY_EXTRDY_EN  : enables EXTRDY-driven EXTWAIT state and TIMEOUT flag
// ---------------------------------------------------------------------------
package mrdy_pkg;

    typedef enum logic [1:0] {
        REGION_ZERO = 2'd0,
        REGION_ROM  = 2'd1,
        REGION_EXT  = 2'd2
    } region_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXTWAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [15:0] EXT_LO     = 16'hFC00;
    localparam logic [15:0] EXT_HI     = 16'hFDFF;
    localparam logic [15:0] ROM_LO     = 16'hC000;
    localparam logic [15:0] ROM_HI     = 16'hFBFF;
    localparam logic [15:0] ROM_VEC_LO = 16'hFFF0;
    localparam logic [15:0] ROM_VEC_HI = 16'hFFFF;

    localparam logic [15:0] ADDR_WSCFG  = 16'hFF92;
    localparam logic [15:0] ADDR_STATUS = 16'hFF93;

    localparam logic [7:0]  WSCFG_RST = 8'h20;

    localparam int unsigned TIMEOUT_LIMIT = 64;
    // Last value of the 6-bit EXTWAIT counter before the timeout fires.
    localparam logic [5:0]  TIMEOUT_LAST  = 6'(TIMEOUT_LIMIT - 1);

    function automatic logic in_range(input logic [15:0] addr,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mrdy_region_decode.sv
// ---------------------------------------------------------------------------
// mrdy_region_decode -- purely combinational CPU address region decoder.
//
// Ports:
//   i_addr   [15:0] : CPU address
//   o_region        : REGION_EXT, REGION_ROM or REGION_ZERO
// ---------------------------------------------------------------------------
module mrdy_region_decode
    import mrdy_pkg::*;
(
    input  logic [15:0] i_addr,
    output region_e     o_region
);

    // Address to region; EXT is checked first because it sits inside C000-FFFF.
    always_comb begin
        o_region = REGION_ZERO;
        if (in_range(i_addr, EXT_LO, EXT_HI)) begin
            o_region = REGION_EXT;
        end else if (in_range(i_addr, ROM_LO, ROM_HI) ||
                     in_range(i_addr, ROM_VEC_LO, ROM_VEC_HI)) begin
            o_region = REGION_ROM;
        end else begin
            o_region = REGION_ZERO;
        end
    end

endmodule

// File: rtl/mrdy_gen.sv
// ---------------------------------------------------------------------------
// mrdy_gen -- wait-state (MRDY) generator for a 6809-style bus.
//
// MRDY is pulled low at the start of an E-high phase for the number of CLKX4
// periods programmed in WSCFG for the addressed region, which makes the bus
// clock generator stretch E high by exactly that many periods.
//
// Ports:
//   CLKX4        in  : single clock, 4x the E rate
//   nRESET       in  : asynchronous active-low reset
//   E, Q         in  : CPU bus clocks (Q is unused by the logic)
//   ADDR [15:0]  in  : CPU address
//   DATA [7:0]   in  : CPU write data
//   RnW          in  : CPU read/not-write
//   BA           in  : bus available (CPU released the bus)
//   EXTRDY       in  : external device ready
//   MRDY         out : memory ready, registered; low stretches E
//   DOUT [7:0]   out : register read data, registered
//   DOE          out : DOUT valid = E & RnW & ADDR in {FF92, FF93}
//
// Registers: FF92 WSCFG [7:4] EXT waits, [3:0] ROM waits (reset 0x20)
//            FF93 STATUS bit0 sticky TIMEOUT, write of any value clears
//
// Build option MRDY_EXTRDY_EN: EXT cycles wait for EXTRDY after the
// programmed count, with a 64-edge timeout that sets TIMEOUT. Without it
// EXTRDY is ignored and TIMEOUT reads 0.
// ---------------------------------------------------------------------------
module mrdy_gen
    import mrdy_pkg::*;
(
    input  logic        CLKX4,
    input  logic        nRESET,
    input  logic        E,
    input  logic        Q,
    input  logic [15:0] ADDR,
    input  logic [7:0]  DATA,
    input  logic        RnW,
    input  logic        BA,
    input  logic        EXTRDY,
    output logic        MRDY,
    output logic [7:0]  DOUT,
    output logic        DOE
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_mrdy;
    logic        w_mrdy_nxt;
    logic        r_is_ext;
    logic        w_is_ext_nxt;
    logic        r_e_prev;
    logic [15:0] r_cap_addr;
    logic        r_cap_rnw;
    logic [7:0]  r_cap_data;
    logic [7:0]  r_wscfg;
    logic [7:0]  r_dout;
    logic [7:0]  w_rd_data;
    logic        w_timeout;
    logic        w_to_set;
    region_e     w_region;
    logic [3:0]  w_wait_n;
    logic        w_start;
    logic        w_commit;
    logic        w_wr_wscfg;
    logic        w_wr_status;

    mrdy_region_decode u_decode (
        .i_addr   (ADDR),
        .o_region (w_region)
    );

    // Cycle start is the first edge that sees E high; commit is the first that sees it low.
    assign w_start     = E & ~r_e_prev;
    assign w_commit    = ~E & r_e_prev;
    assign w_wr_wscfg  = w_commit & ~r_cap_rnw & (r_cap_addr == ADDR_WSCFG);
    assign w_wr_status = w_commit & ~r_cap_rnw & (r_cap_addr == ADDR_STATUS);
    assign w_wait_n    = (w_region == REGION_EXT) ? r_wscfg[7:4] : r_wscfg[3:0];

    assign MRDY = r_mrdy;
    assign DOUT = r_dout;
    assign DOE  = E & RnW & ((ADDR == ADDR_WSCFG) || (ADDR == ADDR_STATUS));

`ifdef MRDY_EXTRDY_EN
    logic [5:0] r_tocnt;
    logic [5:0] w_tocnt_nxt;
    logic       r_timeout;
    logic       w_unused;

    assign w_timeout = r_timeout;
    assign w_unused  = Q;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = Q ^ EXTRDY;
`endif

    // Next-state, counter and MRDY decisions for the wait-state FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_mrdy_nxt   = r_mrdy;
        w_is_ext_nxt = r_is_ext;
        w_to_set     = 1'b0;
`ifdef MRDY_EXTRDY_EN
        w_tocnt_nxt  = r_tocnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_is_ext_nxt = (w_region == REGION_EXT);
                    if (!BA && (w_region != REGION_ZERO) && (w_wait_n != 4'd0)) begin
                        w_mrdy_nxt  = 1'b0;
                        w_cnt_nxt   = w_wait_n;
                        w_state_nxt = ST_COUNT;
                    end else begin
                        w_mrdy_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_mrdy_nxt = 1'b1;
                end
            end
            ST_COUNT: begin
                // Release on the edge that consumes the last count, i.e. N edges after start.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt = 4'd0;
`ifdef MRDY_EXTRDY_EN
                    if (r_is_ext && !EXTRDY) begin
                        w_tocnt_nxt = 6'd0;
                        w_state_nxt = ST_EXTWAIT;
                    end else begin
                        w_mrdy_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
`else
                    w_mrdy_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
`ifdef MRDY_EXTRDY_EN
            ST_EXTWAIT: begin
                if (EXTRDY) begin
                    w_mrdy_nxt  = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_tocnt == TIMEOUT_LAST) begin
                    w_mrdy_nxt  = 1'b1;
                    w_to_set    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tocnt_nxt = r_tocnt + 6'd1;
                end
            end
`endif
            ST_DONE: begin
                w_mrdy_nxt = 1'b1;
                if (!E) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_mrdy_nxt  = 1'b1;
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state, wait counter and registered MRDY.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_mrdy   <= 1'b1;
            r_is_ext <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_mrdy   <= w_mrdy_nxt;
            r_is_ext <= w_is_ext_nxt;
        end
    end

`ifdef MRDY_EXTRDY_EN
    // EXTWAIT timeout counter and sticky TIMEOUT flag; a timeout beats a clear.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            r_tocnt   <= 6'd0;
            r_timeout <= 1'b0;
        end else begin
            r_tocnt <= w_tocnt_nxt;
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end else if (w_wr_status) begin
                r_timeout <= 1'b0;
            end
        end
    end
`endif

    // E history plus capture of the bus transfer while E is high.
    // e_prev resets high so a reset released mid E-high cannot fake a cycle start.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            r_e_prev   <= 1'b1;
            r_cap_addr <= 16'h0000;
            r_cap_rnw  <= 1'b1;
            r_cap_data <= 8'h00;
        end else begin
            r_e_prev <= E;
            if (E) begin
                r_cap_addr <= ADDR;
                r_cap_rnw  <= RnW;
                r_cap_data <= DATA;
            end
        end
    end

    // WSCFG write, committed at the end of the bus cycle so a running count is unaffected.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            r_wscfg <= WSCFG_RST;
        end else if (w_wr_wscfg) begin
            r_wscfg <= r_cap_data;
        end
    end

    // Read data mux for the two registers.
    always_comb begin
        w_rd_data = 8'h00;
        if (ADDR == ADDR_WSCFG) begin
            w_rd_data = r_wscfg;
        end else if (ADDR == ADDR_STATUS) begin
            w_rd_data = {7'b0000000, w_timeout};
        end else begin
            w_rd_data = 8'h00;
        end
    end

    // Registered read data; zero while in reset.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            r_dout <= 8'h00;
        end else begin
            r_dout <= w_rd_data;
        end
    end

endmodule

// File: tb/tb_mrdy_gen.sv
module tb_mrdy_gen;

    logic        CLKX4  = 1'b0;
    logic        nRESET = 1'b0;
    logic        E      = 1'b0;
    logic        Q      = 1'b0;
    logic [15:0] ADDR   = 16'h0000;
    logic [7:0]  DATA   = 8'h00;
    logic        RnW    = 1'b1;
    logic        BA     = 1'b0;
    logic        EXTRDY = 1'b1;
    logic        MRDY;
    logic [7:0]  DOUT;
    logic        DOE;

    int n_checks = 0;
    int n_fail   = 0;

    mrdy_gen dut (
        .CLKX4  (CLKX4),
        .nRESET (nRESET),
        .E      (E),
        .Q      (Q),
        .ADDR   (ADDR),
        .DATA   (DATA),
        .RnW    (RnW),
        .BA     (BA),
        .EXTRDY (EXTRDY),
        .MRDY   (MRDY),
        .DOUT   (DOUT),
        .DOE    (DOE)
    );

    initial begin
        forever #5 CLKX4 = ~CLKX4;
    end

    // Bus clock generator model: E high for 2 CLKX4 periods, low for 2;
    // the second high period is repeated while MRDY (seen before the edge) is low.
    int   ph        = 2;
    logic mrdy_seen = 1'b1;

    always @(negedge CLKX4) mrdy_seen = MRDY;

    always @(posedge CLKX4) begin
        #1;
        if (!(ph == 1 && mrdy_seen == 1'b0)) ph = (ph + 1) % 4;
        E = (ph <= 1);
        Q = (ph == 1) || (ph == 2);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_e(input logic lvl, output logic ok);
        int g;
        g = 0;
        while (E !== lvl && g < 50) begin
            @(negedge CLKX4);
            g++;
        end
        ok = (E === lvl);
    endtask

    // One bus cycle: set up during E low, then count E-high and MRDY-low periods.
    task automatic do_cycle(input logic [15:0] a, input logic rnw, input logic [7:0] d,
                            input logic ba, input logic xr,
                            output int low_n, output int high_n,
                            output logic [7:0] dout_s, output logic doe_s, output logic ok);
        logic ok1, ok2;
        int g;
        wait_e(1'b0, ok1);
        ADDR = a; RnW = rnw; DATA = d; BA = ba; EXTRDY = xr;
        wait_e(1'b1, ok2);
        low_n = 0; high_n = 0; g = 0; dout_s = 8'h00; doe_s = 1'b0;
        while (E === 1'b1 && g < 200) begin
            high_n++;
            if (MRDY === 1'b0) low_n++;
            dout_s = DOUT;
            doe_s  = DOE;
            @(negedge CLKX4);
            g++;
        end
        ok = ok1 && ok2 && (E === 1'b0);
        RnW = 1'b1; BA = 1'b0; EXTRDY = 1'b1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rnw;
        logic [7:0]  data;
        logic        ba;
        logic        xrdy;
        int          exp_low;
        int          exp_high;
        logic        chk_dout;
        logic [7:0]  exp_dout;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v);
        int lo, hi;
        logic [7:0] dq;
        logic dv, ok;
        do_cycle(v.addr, v.rnw, v.data, v.ba, v.xrdy, lo, hi, dq, dv, ok);
        check({v.name, "_done"}, {31'd0, ok}, 32'd1);
        check({v.name, "_mrdy_low"}, lo, v.exp_low);
        check({v.name, "_e_high"}, hi, v.exp_high);
        check({v.name, "_doe"}, {31'd0, dv}, {31'd0, v.chk_dout});
        if (v.chk_dout) check({v.name, "_dout"}, {24'd0, dq}, {24'd0, v.exp_dout});
    endtask

    initial begin
        logic ok;

        // addr, rnw, data, ba, xrdy, low, high, chk_dout, dout, name
        vecs.push_back('{16'hFF92, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h20, "rd_wscfg_rst"});
        vecs.push_back('{16'hFF93, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h00, "rd_status_rst"});
        vecs.push_back('{16'hFF92, 1'b0, 8'h03, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "wr_wscfg_03"});
        vecs.push_back('{16'hFF92, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h03, "rd_wscfg_03"});
        vecs.push_back('{16'hD000, 1'b1, 8'h00, 1'b0, 1'b1, 3, 5, 1'b0, 8'h00, "rd_rom_d000"});
        vecs.push_back('{16'hFE00, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "rd_zero_fe00"});
        vecs.push_back('{16'h1234, 1'b0, 8'h5A, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "wr_zero_1234"});
        vecs.push_back('{16'hFC00, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "rd_ext_n0"});
        vecs.push_back('{16'hFFF0, 1'b1, 8'h00, 1'b0, 1'b1, 3, 5, 1'b0, 8'h00, "rd_vec_fff0"});
        vecs.push_back('{16'hFFEF, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "rd_zero_ffef"});
        vecs.push_back('{16'hBFFF, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "rd_zero_bfff"});
        vecs.push_back('{16'hFF92, 1'b0, 8'h2F, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "wr_wscfg_2f"});
        vecs.push_back('{16'hFC00, 1'b1, 8'h00, 1'b0, 1'b1, 2, 4, 1'b0, 8'h00, "rd_ext_fc00"});
        vecs.push_back('{16'hFDFF, 1'b1, 8'h00, 1'b1, 1'b1, 0, 2, 1'b0, 8'h00, "rd_ext_ba1"});
        vecs.push_back('{16'hFBFF, 1'b1, 8'h00, 1'b0, 1'b1, 15, 17, 1'b0, 8'h00, "rd_rom_fbff"});
        vecs.push_back('{16'hC000, 1'b1, 8'h00, 1'b0, 1'b1, 15, 17, 1'b0, 8'h00, "rd_rom_c000"});
        vecs.push_back('{16'hFF93, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "wr_status"});
        vecs.push_back('{16'hFF93, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h00, "rd_status"});

        // Reset state while nRESET is held low.
        repeat (5) @(negedge CLKX4);
        check("rst_mrdy", {31'd0, MRDY}, 32'd1);
        check("rst_dout", {24'd0, DOUT}, 32'd0);
        nRESET = 1'b1;
        repeat (3) @(negedge CLKX4);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted in the middle of a 15-wait ROM cycle (WSCFG = 0x2F here).
        wait_e(1'b0, ok);
        ADDR = 16'hD000; RnW = 1'b1; BA = 1'b0;
        wait_e(1'b1, ok);
        check("midrst_e_rise", {31'd0, ok}, 32'd1);
        repeat (4) @(negedge CLKX4);
        check("midrst_mrdy_pre", {31'd0, MRDY}, 32'd0);
        #2 nRESET = 1'b0;
        #1;
        check("midrst_mrdy_now", {31'd0, MRDY}, 32'd1);
        check("midrst_dout", {24'd0, DOUT}, 32'd0);
        repeat (3) @(negedge CLKX4);
        nRESET = 1'b1;
        run_vec('{16'hFF92, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h20, "post_rst_wscfg"});
        run_vec('{16'hFC00, 1'b1, 8'h00, 1'b1, 1'b1, 0, 2, 1'b0, 8'h00, "post_rst_ext_ba1"});
        run_vec('{16'hD000, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "post_rst_rom_n0"});

`ifdef MRDY_EXTRDY_EN
        // EXT access with EXTRDY held low: 2 counted waits plus 64 timeout edges.
        run_vec('{16'hFC00, 1'b1, 8'h00, 1'b0, 1'b0, 66, 68, 1'b0, 8'h00, "ext_timeout"});
        run_vec('{16'hFF93, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h01, "timeout_set"});
        run_vec('{16'hFF93, 1'b0, 8'h00, 1'b0, 1'b1, 0, 2, 1'b0, 8'h00, "timeout_clr_wr"});
        run_vec('{16'hFF93, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h00, "timeout_clr"});
`else
        // EXTRDY is ignored: an EXT access with EXTRDY low still takes 2 waits.
        run_vec('{16'hFC00, 1'b1, 8'h00, 1'b0, 1'b0, 2, 4, 1'b0, 8'h00, "ext_extrdy_ign"});
        run_vec('{16'hFF93, 1'b1, 8'h00, 1'b0, 1'b1, 0, 2, 1'b1, 8'h00, "timeout_zero"});
`endif

        // DOE must drop once E is low.
        wait_e(1'b0, ok);
        ADDR = 16'hFF92; RnW = 1'b1;
        #1;
        check("doe_e_low", {31'd0, DOE}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
